// File: rtl/inc_share_arbiter.sv
// inc_share_arbiter
// Shares one registered incrementer (out = in + step) among NREQ requesters.
// A round-robin arbiter picks at most one requester per cycle; the result is
// returned through a single valid/ready port tagged with the requester id.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous active-high reset
//   req        request vector, bit i held until gnt[i] seen
//   in_data    operand i at [i*WIDTH +: WIDTH]
//   gnt        one-hot grant pulse (combinational)
//   out_valid  result register holds a result
//   out_ready  consumer accepts result
//   out_data   in_data[winner] + step_q
//   out_id     winner index
//   cfg_we     load step register from cfg_step
//   cfg_step   new step value
//   busy       out_valid | (|req)
//   sat_flag   only with INC_SHARE_SAT_EN: result was saturated
//
// Optional macro INC_SHARE_SAT_EN: saturate instead of wrap, add sat_flag.
//
// state | meaning
// ------+----------------------------------------
// IDLE  | output register empty, out_valid = 0
// FULL  | output register holds a result, out_valid = 1

module inc_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] in_data,
  output logic [NREQ-1:0]       gnt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [IDW-1:0]        out_id,
  input  logic                  cfg_we,
  input  logic [WIDTH-1:0]      cfg_step,
  output logic                  busy
`ifdef INC_SHARE_SAT_EN
  ,
  output logic                  sat_flag
`endif
);

  generate
    if (IDW != $clog2(NREQ)) begin : g_bad_idw
      $error("inc_share_arbiter: IDW must equal clog2(NREQ)");
    end
    if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
      $error("inc_share_arbiter: NREQ must be in 2..16");
    end
  endgenerate

  typedef enum logic {IDLE = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   next_ptr;
  logic             found;
  logic             can_issue;
  logic             grant;
  logic [WIDTH-1:0] step_q;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] result;
`ifdef INC_SHARE_SAT_EN
  logic [WIDTH:0]   sum_ext;
  logic             sat_d;
`endif

  // The output register frees in the same cycle it is consumed.
  assign can_issue = (state_q == IDLE) | out_ready;

  // First set request at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(rr_ptr) + k) % NREQ]) begin
        found = 1'b1;
        win   = IDW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  // No grant while reset is held, so nothing is promised that will be lost.
  assign grant    = !rst & can_issue & found;
  assign next_ptr = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;

  always_comb begin
    gnt = '0;
    if (grant) gnt[win] = 1'b1;
  end

  assign operand = in_data[int'(win)*WIDTH +: WIDTH];

`ifdef INC_SHARE_SAT_EN
  assign sum_ext = {1'b0, operand} + {1'b0, step_q};
  assign sat_d   = sum_ext[WIDTH];
  assign result  = sat_d ? '1 : sum_ext[WIDTH-1:0];
`else
  assign result  = operand + step_q;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (grant) state_d = FULL;
      FULL: if (out_ready) state_d = grant ? FULL : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    out_valid = (state_q == FULL);
    busy      = (state_q == FULL) | (|req);
  end

  // Datapath: result capture, pointer advance, step register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      out_id   <= '0;
      rr_ptr   <= '0;
      step_q   <= WIDTH'(STEP);
`ifdef INC_SHARE_SAT_EN
      sat_flag <= 1'b0;
`endif
    end else begin
      if (grant) begin
        out_data <= result;
        out_id   <= win;
        rr_ptr   <= next_ptr;
`ifdef INC_SHARE_SAT_EN
        sat_flag <= sat_d;
`endif
      end
      // A grant in this cycle already used the old step value.
      if (cfg_we) step_q <= cfg_step;
    end
  end

endmodule

// File: tb/tb_inc_share_arbiter.sv
module tb_inc_share_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int STEP  = 1;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] in_data;
  logic [NREQ-1:0]       gnt;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [IDW-1:0]        out_id;
  logic                  cfg_we;
  logic [WIDTH-1:0]      cfg_step;
  logic                  busy;
`ifdef INC_SHARE_SAT_EN
  logic                  sat_flag;
`endif

  inc_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .STEP(STEP), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req(req), .in_data(in_data), .gnt(gnt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .cfg_we(cfg_we), .cfg_step(cfg_step), .busy(busy)
`ifdef INC_SHARE_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: plain integers describing the observable contract.
  int m_ptr, m_step, m_data, m_id, m_sat;
  bit m_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_step = STEP % 256; m_data = 0; m_id = 0; m_valid = 0; m_sat = 0;
  endtask

  // Winner index per the round-robin rule, -1 when nothing may be granted.
  function automatic int exp_win();
    if (rst) return -1;
    if (m_valid && !out_ready) return -1;
    for (int k = 0; k < NREQ; k++)
      if (req[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic check_all();
    int w;
    w = exp_win();
    chk("gnt", 32'(gnt), (w < 0) ? 32'd0 : (32'd1 << w));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), m_data);
    chk("out_id", 32'(out_id), m_id);
    chk("busy", 32'(busy), 32'(m_valid | (|req)));
`ifdef INC_SHARE_SAT_EN
    chk("sat_flag", 32'(sat_flag), m_sat);
`endif
  endtask

  task automatic model_edge();
    int w, sum;
    w = exp_win();
    if (rst) begin
      model_reset();
    end else begin
      if (w >= 0) begin
        sum = int'(in_data[w*WIDTH +: WIDTH]) + m_step;
`ifdef INC_SHARE_SAT_EN
        m_sat  = (sum > 255) ? 1 : 0;
        m_data = (sum > 255) ? 255 : sum;
`else
        m_data = sum % 256;
`endif
        m_id = w; m_valid = 1; m_ptr = (w + 1) % NREQ;
      end else if (out_ready) begin
        m_valid = 0;
      end
      if (cfg_we) m_step = int'(cfg_step);
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
    check_all();
  endtask

  task automatic to_pos();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cycle();
    to_neg();
    to_pos();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_async_valid", 32'(out_valid), 32'd0);
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 4'b1111; in_data = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_step = '0;
    model_reset();
    #1;
    // 1: reset then idle
    to_neg();
    chk("t1_rst_gnt", 32'(gnt), 32'd0);
    chk("t1_rst_valid", 32'(out_valid), 32'd0);
    to_pos();
    rst = 1'b0;
    to_neg();
    chk("t1_first_gnt", 32'(gnt), 32'b0001);
    to_pos();
    req = 4'b0000;
    to_neg();
    chk("t1_step_reset", 32'(out_data), 32'h01);
    to_pos();

    // 2: single request
    req = 4'b0100; in_data[23:16] = 8'h10;
    to_neg();
    chk("t2_gnt", 32'(gnt), 32'b0100);
    to_pos();
    req = 4'b0000;
    to_neg();
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_data", 32'(out_data), 32'h11);
    chk("t2_id", 32'(out_id), 32'd2);
    to_pos();

    // 3: round-robin from a fresh pointer
    pulse_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      to_neg();
      chk("t3_gnt", 32'(gnt), 32'd1 << (i % 4));
      if (i > 0) chk("t3_id", 32'(out_id), 32'((i - 1) % 4));
      to_pos();
    end
    req = 4'b0000;
    cycle();

    // 4: backpressure with 0x22 / id 1 held
    pulse_reset();
    req = 4'b0010; in_data[15:8] = 8'h21; in_data[7:0] = 8'h40;
    cycle();
    req = 4'b0001; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      to_neg();
      chk("t4_stall_gnt", 32'(gnt), 32'd0);
      chk("t4_hold_data", 32'(out_data), 32'h22);
      chk("t4_hold_id", 32'(out_id), 32'd1);
      to_pos();
    end
    out_ready = 1'b1;
    to_neg();
    chk("t4_release_gnt", 32'(gnt), 32'b0001);
    to_pos();
    req = 4'b0000;
    to_neg();
    chk("t4_next_data", 32'(out_data), 32'h41);
    to_pos();

    // 5: step reconfig in grant cycle, then wrap / saturate
    req = 4'b0001; in_data[7:0] = 8'hFE; cfg_we = 1'b1; cfg_step = 8'd3;
    to_neg();
    chk("t5_gnt", 32'(gnt), 32'b0001);
    to_pos();
    cfg_we = 1'b0;
    to_neg();
    chk("t5_old_step", 32'(out_data), 32'hFF);
    to_pos();
    req = 4'b0000;
    to_neg();
`ifdef INC_SHARE_SAT_EN
    chk("t5_sat", 32'(out_data), 32'hFF);
    chk("t5_sat_flag", 32'(sat_flag), 32'd1);
`else
    chk("t5_wrap", 32'(out_data), 32'h01);
`endif
    to_pos();

    // Stall with simultaneous cfg_we: step still updates.
    req = 4'b0010; in_data[15:8] = 8'h05;
    cycle();
    req = 4'b0000; out_ready = 1'b0; cfg_we = 1'b1; cfg_step = 8'd7;
    cycle();
    cfg_we = 1'b0; out_ready = 1'b1; req = 4'b0010;
    cycle();
    req = 4'b0000;
    to_neg();
    chk("stall_cfg_step", 32'(out_data), 32'h0C);
    to_pos();

    // 6: reset mid-FULL
    req = 4'b1000; in_data[31:24] = 8'h30;
    cycle();
    req = 4'b0000; out_ready = 1'b0;
    cycle();
    pulse_reset();
    out_ready = 1'b1; req = 4'b1111; in_data[7:0] = 8'h50;
    to_neg();
    chk("t6_ptr_reset", 32'(gnt), 32'b0001);
    to_pos();
    req = 4'b0000;
    to_neg();
    chk("t6_step_reset", 32'(out_data), 32'h51);
    to_pos();

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      req       = NREQ'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(3) != 0);
      cfg_we    = ($urandom_range(7) == 0);
      cfg_step  = WIDTH'($urandom_range(255));
      if ($urandom_range(99) == 0) pulse_reset();
      else cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
